// File: rtl/processor.sv
// rtl/processor.sv - single-cycle 32-bit core with 512x32 instruction memory
// Executes IRMOV/HALT/ALU-op one instruction per clock when working is set.
module processor #(
    parameter int IMEM_AW = 9,
    parameter int NREGS   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [IMEM_AW-1:0] addr,
    input  logic               wEn,
    input  logic [31:0]        wDat,
    input  logic               working,
    output logic [31:0]        valA,
    output logic [31:0]        valB
);

    localparam int IMEM_DEPTH = 1 << IMEM_AW;
    localparam int RW         = $clog2(NREGS);

    localparam logic [3:0] IC_HALT  = 4'h0;
    localparam logic [3:0] IC_IRMOV = 4'h1;
    localparam logic [3:0] IC_OP0   = 4'h2;
    localparam logic [3:0] IC_OP1   = 4'h3;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_XOR = 4'h3;

    logic [31:0]        mem_q [IMEM_DEPTH];
    logic [31:0]        regs_q [NREGS];
    logic [IMEM_AW-1:0] pc_q;
    logic [IMEM_AW-1:0] pc_d;

    logic [31:0] instr;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
    logic        a_ok;
    logic        b_ok;

    logic          wr_en;
    logic [RW-1:0] wr_idx;
    logic [31:0]   wr_data;

    assign instr = mem_q[pc_q];
    assign icode = instr[31:28];
    assign ifun  = instr[27:24];
    assign ra    = instr[23:20];
    assign rb    = instr[19:16];
    assign imm   = instr[15:0];

    // Indices beyond the register file (0xF = none) read as zero and are never written.
    assign a_ok = ({28'd0, ra} < NREGS);
    assign b_ok = ({28'd0, rb} < NREGS);

    assign valA   = a_ok ? regs_q[ra[RW-1:0]] : 32'd0;
    assign valB   = b_ok ? regs_q[rb[RW-1:0]] : 32'd0;
    assign wr_idx = rb[RW-1:0];

    always_comb begin
        pc_d    = pc_q;
        wr_en   = 1'b0;
        wr_data = 32'd0;
        if (working) begin
            if (icode != IC_HALT) begin
                pc_d = pc_q + IMEM_AW'(1);
            end
            case (icode)
                IC_IRMOV: begin
                    wr_en   = b_ok;
                    wr_data = {16'd0, imm};
                end
                IC_OP0, IC_OP1: begin
                    case (ifun)
                        FN_ADD: begin wr_en = b_ok; wr_data = valB + valA; end
                        FN_SUB: begin wr_en = b_ok; wr_data = valB - valA; end
                        FN_AND: begin wr_en = b_ok; wr_data = valB & valA; end
                        FN_XOR: begin wr_en = b_ok; wr_data = valB ^ valA; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Memory is not reset so a loaded program survives a core reset.
    always_ff @(posedge clock) begin
        if (wEn) begin
            mem_q[addr] <= wDat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q <= pc_d;
            if (wr_en) begin
                regs_q[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed self-checking bench for processor
module tb_processor;

    logic        clock;
    logic        reset;
    logic [8:0]  addr;
    logic        wEn;
    logic [31:0] wDat;
    logic        working;
    logic [31:0] valA;
    logic [31:0] valB;

    int total;
    int bad;

    processor dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .wEn     (wEn),
        .wDat    (wDat),
        .working (working),
        .valA    (valA),
        .valB    (valB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        addr = a;
        wDat = d;
        wEn  = 1'b1;
        step();
        wEn  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [31:0] prog1 [9];
    logic [31:0] exp_a [9];
    logic [31:0] exp_b [9];
    logic [31:0] exp_r [8];

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        working = 1'b0;
        wEn     = 1'b0;
        addr    = '0;
        wDat    = '0;
        prog1 = '{32'h10F0001C, 32'h10F1001D, 32'h10F2001E, 32'h10F3001F, 32'h10F40020,
                  32'h10F50021, 32'h20100000, 32'h21320000, 32'h32450000};
        exp_a = '{0, 0, 0, 0, 0, 0, 29, 31, 32};
        exp_b = '{0, 0, 0, 0, 0, 0, 28, 30, 33};
        exp_r = '{57, 29, 32'hFFFFFFFF, 31, 32, 32, 0, 0};
        step(2);
        reset = 1'b0;

        check("rst_pc", 32'(dut.pc_q), 0);
        check("rst_valA", valA, 0);
        check("rst_valB", valB, 0);

        for (int i = 0; i < 9; i++) wr(9'(i), prog1[i]);
        wr(9'd9, 32'h0);
        check("load_pc_idle", 32'(dut.pc_q), 0);

        working = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("run_pc%0d", k), 32'(dut.pc_q), k);
            check($sformatf("run_valA%0d", k), valA, exp_a[k]);
            check($sformatf("run_valB%0d", k), valB, exp_b[k]);
            step();
        end

        step(10);
        check("halt_pc", 32'(dut.pc_q), 9);
        check("halt_valA", valA, 57);
        check("halt_valB", valB, 57);
        for (int i = 0; i < 8; i++) check($sformatf("final_r%0d", i), dut.regs_q[i], exp_r[i]);

        do_reset();
        step(3);
        working = 1'b0;
        step(5);
        check("idle_pc", 32'(dut.pc_q), 3);
        check("idle_r2", dut.regs_q[2], 30);
        check("idle_r3", dut.regs_q[3], 0);
        working = 1'b1;
        step(3);
        check("resume_pc", 32'(dut.pc_q), 6);
        check("resume_r3", dut.regs_q[3], 31);
        check("resume_r5", dut.regs_q[5], 33);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_pc", 32'(dut.pc_q), 0);
        for (int i = 0; i < 8; i++) check($sformatf("midrst_r%0d", i), dut.regs_q[i], 0);
        step();
        check("midrst_pc1", 32'(dut.pc_q), 1);
        check("midrst_r0", dut.regs_q[0], 28);

        working = 1'b0;
        do_reset();
        wr(9'd0, 32'h10F1FFFF);
        wr(9'd1, 32'h10F200FF);
        wr(9'd2, 32'h23120000);
        wr(9'd3, 32'h10F71111);
        wr(9'd4, 32'h10F81234);
        wr(9'd5, 32'h20F10000);
        wr(9'd6, 32'h00000000);
        working = 1'b1;
        step(3);
        check("xor_r2", dut.regs_q[2], 32'h0000FF00);
        check("xor_r1", dut.regs_q[1], 32'h0000FFFF);
        step(2);
        check("none_pc", 32'(dut.pc_q), 5);
        check("none_r7", dut.regs_q[7], 32'h00001111);
        check("none_r0", dut.regs_q[0], 0);
        check("none_r3", dut.regs_q[3], 0);
        check("none_valA", valA, 0);
        check("none_valB", valB, 32'h0000FFFF);
        step();
        check("none_add_r1", dut.regs_q[1], 32'h0000FFFF);
        step(3);
        check("none_halt_pc", 32'(dut.pc_q), 6);

        working = 1'b0;
        do_reset();
        for (int i = 0; i < 512; i++) wr(9'(i), 32'h40000000);
        working = 1'b1;
        step(511);
        check("wrap_pc511", 32'(dut.pc_q), 511);
        step();
        check("wrap_pc0", 32'(dut.pc_q), 0);
        check("wrap_r0", dut.regs_q[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
